// File: rtl/rr_tenure_arbiter.sv
// rr_tenure_arbiter
//   Round-robin arbiter that shares one resource among N requesters. The
//   current owner keeps the grant while it requests, but once it has held
//   the grant for MAX_HOLD consecutive cycles and someone else is waiting,
//   the grant moves on to the next requester in round-robin order.
//
// Ports
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high reset
//   req      : [N-1:0] request vector, bit i held high while requester i wants the resource
//   grant    : [N-1:0] registered one-hot grant, all-zero when idle
//   grant_id : [IDW-1:0] index of the current owner, 0 when idle
//   busy     : high whenever any grant bit is high
//   preempt  : one-cycle pulse in the first cycle after a tenure-expiry handover
module rr_tenure_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8,
   parameter int IDW      = 2
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] grant_id,
   output logic           busy,
   output logic           preempt
);

   localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
   localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);
   localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state_r,       state_n;
   logic [N-1:0]     grant_r,       grant_n;
   logic [IDW-1:0]   grant_id_r,    grant_id_n;
   logic [HCW-1:0]   hold_cnt_r,    hold_cnt_n;
   logic [IDW-1:0]   last_winner_r, last_winner_n;
   logic             busy_r,        busy_n;
   logic             preempt_r,     preempt_n;

   logic [N-1:0]     others_s;
   logic [IDW:0]     idle_pick_s;
   logic [IDW:0]     grant_pick_s;

   // Round-robin search: first set bit of cand starting at base+1 and wrapping.
   // Returns {found, index}. base itself is visited last, so when base is the
   // owner and its bit is masked out the owner is effectively excluded.
   function automatic logic [IDW:0] rr_pick(input logic [N-1:0]   cand,
                                             input logic [IDW-1:0] base);
      logic           found;
      logic           hit;
      logic [IDW-1:0] win;
      int             idx;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= N; k++) begin
         idx   = (int'(base) + k >= N) ? (int'(base) + k - N) : (int'(base) + k);
         hit   = !found && cand[idx[IDW-1:0]];
         win   = hit ? idx[IDW-1:0] : win;
         found = found | hit;
      end
      return {found, win};
   endfunction

   // One-hot decode of an owner index.
   function automatic logic [N-1:0] onehot(input logic [IDW-1:0] id);
      logic [N-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Next-state and next-output computation for the IDLE/GRANT machine.
   always_comb begin
      state_n       = state_r;
      grant_n       = grant_r;
      grant_id_n    = grant_id_r;
      hold_cnt_n    = hold_cnt_r;
      last_winner_n = last_winner_r;
      preempt_n     = 1'b0;

      // In GRANT, grant_r is the owner's one-hot, so this masks the owner out.
      others_s     = req & ~grant_r;
      idle_pick_s  = rr_pick(req, last_winner_r);
      grant_pick_s = rr_pick(others_s, grant_id_r);

      case (state_r)
         IDLE: begin
            if (idle_pick_s[IDW]) begin
               state_n       = GRANT;
               grant_id_n    = idle_pick_s[IDW-1:0];
               grant_n       = onehot(idle_pick_s[IDW-1:0]);
               last_winner_n = idle_pick_s[IDW-1:0];
               hold_cnt_n    = '0;
            end else begin
               state_n = IDLE;
            end
         end
         GRANT: begin
            if (!req[grant_id_r]) begin
               // Voluntary release wins over expiry, so preempt stays low here.
               if (grant_pick_s[IDW]) begin
                  grant_id_n    = grant_pick_s[IDW-1:0];
                  grant_n       = onehot(grant_pick_s[IDW-1:0]);
                  last_winner_n = grant_pick_s[IDW-1:0];
                  hold_cnt_n    = '0;
               end else begin
                  state_n    = IDLE;
                  grant_n    = '0;
                  grant_id_n = '0;
                  hold_cnt_n = '0;
               end
            end else if (hold_cnt_r == HOLD_LAST) begin
               if (grant_pick_s[IDW]) begin
                  grant_id_n    = grant_pick_s[IDW-1:0];
                  grant_n       = onehot(grant_pick_s[IDW-1:0]);
                  last_winner_n = grant_pick_s[IDW-1:0];
                  hold_cnt_n    = '0;
                  preempt_n     = 1'b1;
               end else begin
                  // Nobody else waiting: renew the tenure instead of handing over.
                  hold_cnt_n = '0;
               end
            end else begin
               hold_cnt_n = hold_cnt_r + HOLD_ONE;
            end
         end
         default: begin
            state_n       = IDLE;
            grant_n       = '0;
            grant_id_n    = '0;
            hold_cnt_n    = '0;
            last_winner_n = LAST_INIT;
         end
      endcase

      busy_n = |grant_n;
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= IDLE;
         grant_r       <= '0;
         grant_id_r    <= '0;
         hold_cnt_r    <= '0;
         last_winner_r <= LAST_INIT;
         busy_r        <= 1'b0;
         preempt_r     <= 1'b0;
      end else begin
         state_r       <= state_n;
         grant_r       <= grant_n;
         grant_id_r    <= grant_id_n;
         hold_cnt_r    <= hold_cnt_n;
         last_winner_r <= last_winner_n;
         busy_r        <= busy_n;
         preempt_r     <= preempt_n;
      end
   end

   assign grant    = grant_r;
   assign grant_id = grant_id_r;
   assign busy     = busy_r;
   assign preempt  = preempt_r;

endmodule

// File: doc/rr_tenure_arbiter.md
Name: rr_tenure_arbiter

Overview:
- Round-robin arbiter sharing one resource among N requesters.
- Generalises the team's two-requester R0/R1 → G0/G1 grant FSM to N requesters.
- Adds a bounded tenure so one requester cannot starve the others.
- Sits between requesting masters and the shared resource; grants are registered and one-hot.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester waits (≥2).
- IDW, 2, width of grant_id; must equal clog2(N).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i is held high while requester i wants the resource.
- grant  output  N  registered one-hot grant; all-zero when idle.
- grant_id  output  IDW  index of the current owner; 0 when idle.
- busy  output  1  high whenever any grant bit is high.
- preempt  output  1  one-cycle pulse in the cycle after an owner loses its grant through tenure expiry.

Behaviour:
- Reset values (asynchronous, active-high):
  - grant=0, grant_id=0, busy=0, preempt=0.
  - hold_cnt=0, state=IDLE.
  - last_winner=N-1, so requester 0 has highest priority after reset.
- All outputs are registered. There is no combinational path from req to any output.
- Winner selection: the first i with req[i]=1, searching from (last_winner+1) mod N and wrapping upward.
  - In GRANT, the search starts at owner+1 and excludes the owner.
- State machine: IDLE and GRANT(owner).
- IDLE:
  - If req≠0 at a rising edge: grant the winner, set last_winner=winner, hold_cnt=0, go to GRANT.
  - Otherwise stay in IDLE.
  - Latency: a request sampled at edge k drives grant high after edge k.
- GRANT(owner), evaluated at each rising edge in this priority order:
  1. req[owner]=0 (voluntary release):
     - If any other req is high, switch directly to the next winner with no idle gap; hold_cnt=0; preempt=0.
     - Otherwise go to IDLE and clear grant.
  2. req[owner]=1, hold_cnt=MAX_HOLD-1, and another req is high (expiry):
     - Switch to the next winner; hold_cnt=0; preempt=1 for one cycle.
  3. req[owner]=1, hold_cnt=MAX_HOLD-1, and no other req is high:
     - Keep the grant; hold_cnt wraps to 0 (tenure renewed); preempt=0.
  4. Otherwise: keep the grant; hold_cnt+1; preempt=0.
- Tenure: an owner holds the grant for at most MAX_HOLD consecutive cycles while contended.
- hold_cnt is clog2(MAX_HOLD) bits wide and never exceeds MAX_HOLD-1.
- Simultaneous events:
  - Owner deasserts in the same cycle as expiry: treat as voluntary release (preempt=0).
  - Multiple new requests in one cycle: round-robin order decides; no request is lost as long as it stays high.
- Fairness: with all N requesting continuously, each requester receives exactly MAX_HOLD cycles in cyclic order 0,1,…,N-1,0,…
- Requesters must hold req until granted; dropping req before the grant is legal and simply withdraws the request.
- Reset mid-operation:
  - All outputs clear immediately (asynchronous).
  - After reset deasserts, arbitration restarts with requester 0 first.
- grant is always one-hot or zero; grant_id and busy are consistent with grant in every cycle.

Test Plan:
1. Reset with req=4'b0000 → grant=0, busy=0, grant_id=0. Then req=4'b0110 → one cycle later grant=4'b0010, grant_id=1.
2. Round robin: req=4'b1111 held, MAX_HOLD=8 → grant rotates 0001→0010→0100→1000→0001. Each owner holds 8 cycles. preempt pulses once at each change.
3. Voluntary release: owner 2 with req=4'b0101; drop req[2] → next cycle grant=4'b0001 with no idle gap, preempt=0. Drop req[0] → grant=0, busy=0.
4. Uncontended renewal: req=4'b1000 only, held 20 cycles → grant stays 4'b1000 throughout, preempt never asserts.
5. Simultaneous release and expiry: owner 1 at hold_cnt=7 drops req[1] while req[3]=1 → grant=4'b1000, preempt=0.
6. Async reset mid-grant: pulse reset between clock edges → grant=0 immediately. Release reset with req=4'b1001 → grant=4'b0001 first.
